swap_arbiter: RTL and testbench
===============================

SWAP_ARBITER -- requirements
Module: swap_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each per-requester served counter.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on posedge clk.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, requester has a word pending.
REQ-005 SHALL have ports req0_data / req1_data, input, 32 each, word to transform.
REQ-006 SHALL have ports req0_mode / req1_mode, input, 2 each, transform select.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each, request accepted this cycle.
REQ-008 SHALL have port resp_valid, output, 1, result register holds a word.
REQ-009 SHALL have port resp_data, output, 32, transformed word.
REQ-010 SHALL have port resp_id, output, 1, index of the requester that produced resp_data.
REQ-011 SHALL have port resp_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have ports served0 / served1, output, CNT_W each, accepted-request counters.

Function
REQ-013 SHALL share one 32-bit byte-order transform unit between two requesters.
REQ-014 Transform SHALL be: mode 00 passthrough; 01 full byte reverse {d[7:0],d[15:8],d[23:16],d[31:24]}; 10 halfword swap {d[15:0],d[31:16]}; 11 byte swap within halfwords {d[23:16],d[31:24],d[7:0],d[15:8]}.
REQ-015 Result register FSM SHALL have two states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-016 Accept condition SHALL be: state EMPTY, or state FULL with resp_ready=1 in the same cycle (drain-and-refill, no bubble).
REQ-017 Grant SHALL be: only one req valid -> that one; both valid -> requester indicated by round-robin pointer rr; none valid -> no grant.
REQ-018 reqN_ready SHALL be combinational: 1 only when accept condition holds and N is granted; never 1 for both in one cycle.
REQ-019 reqN_ready SHALL NOT depend on reqN_valid of the other requester except through grant selection.
REQ-020 On accept (grant & accept condition), result register SHALL load transform(data, mode) and resp_id=N at the next edge; latency request-accept to resp_valid = 1 cycle.
REQ-021 On accept of N, rr SHALL become the other requester (1-N); rr SHALL be unchanged when nothing is accepted.
REQ-022 Transitions: EMPTY->FULL on accept; FULL->EMPTY on resp_ready with no accept; FULL->FULL on accept, or on resp_ready=0.
REQ-023 In FULL with resp_ready=0, resp_data and resp_id SHALL hold stable and both readies SHALL be 0.
REQ-024 servedN SHALL increment by 1 on each accept of N, wrapping from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-025 Requesters SHALL keep valid/data/mode stable until ready; block behaviour with a request withdrawn before ready is undefined.

Reset
REQ-026 With rst=1 at an edge: state EMPTY, resp_valid=0, resp_data=0, resp_id=0, rr=0, served0=served1=0.
REQ-027 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-028 Reset mid-operation SHALL discard any held result without a resp handshake; first accept after reset SHALL favour requester 0 on contention.

Verification
REQ-029 req0 32'hdeadbeef mode 01, resp_ready=1 -> next cycle resp_valid=1, resp_data=32'hefbeadde, resp_id=0, served0=1.
REQ-030 req1 32'hfeedface mode 01 and mode 10 in turn -> resp_data 32'hcefaedfe then 32'hfacefeed, resp_id=1.
REQ-031 Both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 on back-to-back cycles, one result per cycle.
REQ-032 resp_ready=0 for 5 cycles with result 32'h12345678 held -> resp_data stable, readies 0; resp_ready=1 -> drain and refill in the same cycle.
REQ-033 rst asserted while FULL with both req valid -> next cycle resp_valid=0, counters 0; after release, req0 granted first.
REQ-034 CNT_W=4, 17 accepts from req0 -> served0 = 1 (wrapped), served1 = 0.

Source files
------------

// File: rtl/swap_arbiter.sv
// Two-requester arbiter sharing one 32-bit byte-order transform unit.
// Ports:
//   clk, rst (sync, active-high)
//   reqN_valid/data/mode in, reqN_ready out (N = 0, 1)
//   resp_valid/data/id out, resp_ready in
//   served0/served1: per-requester accept counters (CNT_W bits)
module swap_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  input  logic [1:0]       req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  input  logic [1:0]       req1_mode,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  output logic             resp_id,
  input  logic             resp_ready,
  output logic [CNT_W-1:0] served0,
  output logic [CNT_W-1:0] served1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             rr_q;
  logic [31:0]      data_q;
  logic             id_q;
  logic [CNT_W-1:0] served0_q;
  logic [CNT_W-1:0] served1_q;

  logic        any_v;
  logic        gnt;
  logic        acc_ok;
  logic        accept;
  logic [31:0] sel_data;
  logic [1:0]  sel_mode;

  function automatic logic [31:0] xform(
    input logic [31:0] d,
    input logic [1:0]  m
  );
    logic [31:0] r;
    r = d;
    unique case (m)
      2'b00: r = d;
      2'b01: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
      2'b10: r = {d[15:0], d[31:16]};
      2'b11: r = {d[23:16], d[31:24], d[7:0], d[15:8]};
      default: r = d;
    endcase
    return r;
  endfunction

  // The round-robin pointer only matters on contention;
  // a lone requester is always the grantee.
  assign any_v  = req0_valid | req1_valid;
  assign gnt    = (req0_valid & req1_valid) ? rr_q : req1_valid;
  // Full register may drain and refill in the same cycle.
  assign acc_ok = !rst && ((state_q == EMPTY) || resp_ready);
  assign accept = acc_ok & any_v;

  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept & gnt;

  assign sel_data = gnt ? req1_data : req0_data;
  assign sel_mode = gnt ? req1_mode : req0_mode;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (!accept && resp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      rr_q      <= 1'b0;
      data_q    <= '0;
      id_q      <= 1'b0;
      served0_q <= '0;
      served1_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= xform(sel_data, sel_mode);
        id_q   <= gnt;
        rr_q   <= ~gnt;
      end
      if (req0_ready) served0_q <= served0_q + 1'b1;
      if (req1_ready) served1_q <= served1_q + 1'b1;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign served0    = served0_q;
  assign served1    = served1_q;

endmodule

// File: tb/tb_swap_arbiter.sv
// Directed testbench for swap_arbiter.
// Instance uses CNT_W=4 so counter wrap is reachable.
module tb_swap_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        resp_ready;
  logic [3:0]  served0;
  logic [3:0]  served1;

  int n_cmp;
  int n_bad;

  swap_arbiter #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_mode  (req0_mode),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_mode  (req1_mode),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .served0    (served0),
    .served1    (served1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    tick();
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_valid got %b want 0", resp_valid);
    end
    n_cmp++;
    if (resp_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_data got %h want 0", resp_data);
    end
    n_cmp++;
    if (resp_id !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_id got %b want 0", resp_id);
    end
    n_cmp++;
    if ({served0, served1} !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_served got %h/%h want 0/0", served0, served1);
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_ready got %b%b want 00", req0_ready, req1_ready);
    end
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_transform;
    req0_valid = 1'b1;
    req0_data  = 32'hdeadbeef;
    req0_mode  = 2'b01;
    resp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL xf_ready got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hefbeadde || resp_id !== 1'b0) begin
      n_bad++;
      $display("FAIL xf_resp got v=%b %h id=%b want v=1 efbeadde id=0", resp_valid, resp_data, resp_id);
    end
    n_cmp++;
    if (served0 !== 4'd1) begin
      n_bad++;
      $display("FAIL xf_served0 got %0d want 1", served0);
    end
    tick();
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL xf_drain got %b want 0", resp_valid);
    end
  endtask

  task automatic test_modes;
    req1_valid = 1'b1;
    req1_data  = 32'hfeedface;
    req1_mode  = 2'b01;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL md_ready got %b%b want 01", req0_ready, req1_ready);
    end
    tick();
    n_cmp++;
    if (resp_data !== 32'hcefaedfe || resp_id !== 1'b1) begin
      n_bad++;
      $display("FAIL md_rev got %h id=%b want cefaedfe id=1", resp_data, resp_id);
    end
    req1_mode = 2'b10;
    tick();
    n_cmp++;
    if (resp_data !== 32'hfacefeed || resp_id !== 1'b1) begin
      n_bad++;
      $display("FAIL md_half got %h id=%b want facefeed id=1", resp_data, resp_id);
    end
    req1_mode = 2'b11;
    tick();
    n_cmp++;
    if (resp_data !== 32'hedfecefa) begin
      n_bad++;
      $display("FAIL md_bswap got %h want edfecefa", resp_data);
    end
    req1_mode = 2'b00;
    tick();
    n_cmp++;
    if (resp_data !== 32'hfeedface) begin
      n_bad++;
      $display("FAIL md_pass got %h want feedface", resp_data);
    end
    n_cmp++;
    if (served1 !== 4'd4) begin
      n_bad++;
      $display("FAIL md_served1 got %0d want 4", served1);
    end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic exp;
    req0_valid = 1'b1;
    req0_data  = 32'h11223344;
    req0_mode  = 2'b00;
    req1_valid = 1'b1;
    req1_data  = 32'haabbccdd;
    req1_mode  = 2'b00;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2) == 1;
      #1;
      n_cmp++;
      if (req0_ready !== !exp || req1_ready !== exp) begin
        n_bad++;
        $display("FAIL b2b_ready[%0d] got %b%b want %b%b", i, req0_ready, req1_ready, !exp, exp);
      end
      tick();
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_id !== exp ||
          resp_data !== (exp ? 32'haabbccdd : 32'h11223344)) begin
        n_bad++;
        $display("FAIL b2b_resp[%0d] got v=%b id=%b %h want id=%b", i, resp_valid, resp_id, resp_data, exp);
      end
    end
    n_cmp++;
    if (served0 !== 4'd3 || served1 !== 4'd6) begin
      n_bad++;
      $display("FAIL b2b_served got %0d/%0d want 3/6", served0, served1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall;
    req0_valid = 1'b1;
    req0_data  = 32'h12345678;
    req0_mode  = 2'b00;
    resp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    resp_ready = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 32'h0badf00d;
    req1_mode  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_bad++;
        $display("FAIL st_ready[%0d] got %b%b want 00", i, req0_ready, req1_ready);
      end
      tick();
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h12345678 || resp_id !== 1'b0) begin
        n_bad++;
        $display("FAIL st_hold[%0d] got v=%b %h id=%b want v=1 12345678 id=0", i, resp_valid, resp_data, resp_id);
      end
    end
    resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL st_refill_rdy got %b want 1", req1_ready);
    end
    tick();
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h0badf00d || resp_id !== 1'b1) begin
      n_bad++;
      $display("FAIL st_refill got v=%b %h id=%b want v=1 0badf00d id=1", resp_valid, resp_data, resp_id);
    end
    n_cmp++;
    if (served0 !== 4'd4 || served1 !== 4'd7) begin
      n_bad++;
      $display("FAIL st_served got %0d/%0d want 4/7", served0, served1);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    req0_valid = 1'b1;
    req0_data  = 32'h00000001;
    req0_mode  = 2'b00;
    resp_ready = 1'b1;
    tick();
    req1_valid = 1'b1;
    resp_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL rm_ready got %b%b want 00", req0_ready, req1_ready);
    end
    tick();
    rst = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rm_flush got v=%b %h want v=0 0", resp_valid, resp_data);
    end
    n_cmp++;
    if (served0 !== 4'd0 || served1 !== 4'd0) begin
      n_bad++;
      $display("FAIL rm_served got %0d/%0d want 0/0", served0, served1);
    end
    resp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL rm_first got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    n_cmp++;
    if (resp_id !== 1'b0 || served0 !== 4'd1) begin
      n_bad++;
      $display("FAIL rm_resp got id=%b s0=%0d want id=0 s0=1", resp_id, served0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 32'hcafebabe;
    req0_mode  = 2'b10;
    resp_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 16) begin
        n_cmp++;
        if (served0 !== 4'd0) begin
          n_bad++;
          $display("FAIL wr_16 got %0d want 0", served0);
        end
      end
    end
    n_cmp++;
    if (served0 !== 4'd1 || served1 !== 4'd0) begin
      n_bad++;
      $display("FAIL wr_17 got %0d/%0d want 1/0", served0, served1);
    end
    n_cmp++;
    if (resp_data !== 32'hbabecafe) begin
      n_bad++;
      $display("FAIL wr_data got %h want babecafe", resp_data);
    end
    req0_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req0_valid = 1'b0;
    req0_data  = '0;
    req0_mode  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    req1_mode  = '0;
    resp_ready = 1'b0;
    test_reset();
    test_transform();
    test_modes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
